// File: rtl/arm_ins_encoder_pkg.sv
// arm_ins_encoder_pkg
// Definitions shared by the ARM instruction encoder and decoder:
// condition codes, PC register number, shift types, request kinds,
// data-processing opcode names and encoder FSM states.
// Also holds the request struct and a rotate-left helper.
package arm_ins_encoder_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
    } shift_e;

    typedef enum logic [1:0] {
        KIND_DP_REG = 2'd0, KIND_DP_IMM = 2'd1, KIND_BRANCH = 2'd2, KIND_RSVD = 2'd3
    } kind_e;

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } dp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0, ST_SEARCH = 2'd1, ST_EMIT = 2'd2
    } state_e;

    // Request fields captured on the accept cycle.
    typedef struct packed {
        kind_e       kind;
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        setflags;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [1:0]  shifttype;
        logic [4:0]  shiftby;
        logic [31:0] imm32;
        logic        link;
        logic [23:0] offset;
    } enc_req_t;

    // Rotate left; sh == 0 returns x unchanged.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] w;
        w = {x, x} << sh;
        return w[63:32];
    endfunction

endpackage

// File: rtl/arm_imm_fit.sv
// arm_imm_fit
// Combinational test of one ARM immediate rotation.
// The value is encodable at rotation r when rol(imm32, 2r) fits in 8 bits.
// Ports:
//   imm32 - value to encode
//   r     - candidate rotation (rotate amount is 2*r)
//   hit   - value fits at this rotation
//   imm8  - low byte of the rotated candidate
module arm_imm_fit
    import arm_ins_encoder_pkg::*;
(
    input  logic [31:0] imm32,
    input  logic [3:0]  r,
    output logic        hit,
    output logic [7:0]  imm8
);

    logic [31:0] cand;

    assign cand = rol32(imm32, {r, 1'b0});
    assign hit  = (cand[31:8] == 24'd0);
    assign imm8 = cand[7:0];

endmodule

// File: rtl/arm_ins_encoder.sv
// arm_ins_encoder
// Packs decoded ARM fields into a 32-bit instruction word: data processing
// with a shifted register, data processing with an immediate, and B/BL.
// The immediate rotate is searched one rotation per cycle, smallest first.
// Build option: define ARM_ENC_FASTIMM_EN to test all rotations in parallel
// in a single SEARCH cycle (priority pick of the lowest hit).
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - request handshake (ready only when idle)
//   in_kind .. in_offset  - request fields, sampled on the accept cycle
//   out_valid/out_ready   - result handshake
//   out_ins, out_err      - encoded word; err flags unencodable requests
module arm_ins_encoder
    import arm_ins_encoder_pkg::*;
#(
    parameter int ROT_STEPS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_opcode,
    input  logic        in_setflags,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rm,
    input  logic [1:0]  in_shifttype,
    input  logic [4:0]  in_shiftby,
    input  logic [31:0] in_imm32,
    input  logic        in_link,
    input  logic [23:0] in_offset,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic        out_err
);

    state_e     state, state_nx;
    enc_req_t   req_q;
    logic [3:0] rot_q;
    logic [7:0] imm8_q;
    logic       fit_err_q;
    logic       accept;

    // Result of the current SEARCH cycle.
    logic       srch_done;
    logic       srch_hit;
    logic [3:0] srch_rot;
    logic [7:0] srch_imm8;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;

`ifdef ARM_ENC_FASTIMM_EN
    logic [ROT_STEPS-1:0]      hits;
    logic [ROT_STEPS-1:0][7:0] imm8s;

    for (genvar g = 0; g < ROT_STEPS; g++) begin : g_fit
        arm_imm_fit u_fit (
            .imm32 (req_q.imm32),
            .r     (4'(g)),
            .hit   (hits[g]),
            .imm8  (imm8s[g])
        );
    end

    // Walk from the top down so the lowest hit is the one left standing.
    always_comb begin
        srch_hit  = 1'b0;
        srch_rot  = 4'd0;
        srch_imm8 = 8'd0;
        for (int i = ROT_STEPS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                srch_hit  = 1'b1;
                srch_rot  = 4'(i);
                srch_imm8 = imm8s[i];
            end
        end
    end

    assign srch_done = 1'b1;
`else
    logic [3:0] r_q;

    arm_imm_fit u_fit (
        .imm32 (req_q.imm32),
        .r     (r_q),
        .hit   (srch_hit),
        .imm8  (srch_imm8)
    );

    assign srch_rot  = r_q;
    assign srch_done = srch_hit || (r_q == 4'(ROT_STEPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              r_q <= 4'd0;
        else if (accept)                         r_q <= 4'd0;
        else if (state == ST_SEARCH && !srch_done) r_q <= r_q + 4'd1;
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = (kind_e'(in_kind) == KIND_DP_IMM) ? ST_SEARCH : ST_EMIT;
            ST_SEARCH: if (srch_done) state_nx = ST_EMIT;
            ST_EMIT:   if (out_valid && out_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Word assembled from the captured request and search result.
    logic [31:0] enc_ins;
    logic        enc_err;

    always_comb begin
        enc_ins = 32'd0;
        enc_err = 1'b0;
        case (req_q.kind)
            KIND_DP_REG: enc_ins = {req_q.cond, 2'b00, 1'b0, req_q.opcode, req_q.setflags,
                                    req_q.rn, req_q.rd, req_q.shiftby, req_q.shifttype,
                                    1'b0, req_q.rm};
            KIND_DP_IMM: begin
                enc_err = fit_err_q;
                if (!fit_err_q)
                    enc_ins = {req_q.cond, 2'b00, 1'b1, req_q.opcode, req_q.setflags,
                               req_q.rn, req_q.rd, rot_q, imm8_q};
            end
            KIND_BRANCH: enc_ins = {req_q.cond, 3'b101, req_q.link, req_q.offset};
            default:     enc_err = 1'b1;
        endcase
    end

    // Datapath: request capture, search result, output holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            rot_q     <= 4'd0;
            imm8_q    <= 8'd0;
            fit_err_q <= 1'b0;
            out_valid <= 1'b0;
            out_ins   <= 32'd0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{kind: kind_e'(in_kind), cond: in_cond, opcode: in_opcode,
                           setflags: in_setflags, rn: in_rn, rd: in_rd, rm: in_rm,
                           shifttype: in_shifttype, shiftby: in_shiftby, imm32: in_imm32,
                           link: in_link, offset: in_offset};
                fit_err_q <= 1'b0;
            end
            if (state == ST_SEARCH && srch_done) begin
                rot_q     <= srch_rot;
                imm8_q    <= srch_imm8;
                fit_err_q <= !srch_hit;
            end
            // Output is registered one cycle after entering EMIT and held
            // until the consumer takes it.
            if (state == ST_EMIT) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_ins   <= enc_ins;
                    out_err   <= enc_err;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arm_ins_encoder.sv
module tb_arm_ins_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  in_kind;
    logic [3:0]  in_cond, in_opcode, in_rn, in_rd, in_rm;
    logic        in_setflags, in_link;
    logic [1:0]  in_shifttype;
    logic [4:0]  in_shiftby;
    logic [31:0] in_imm32;
    logic [23:0] in_offset;
    logic        out_valid, out_ready, out_err;
    logic [31:0] out_ins;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_ins;
    logic        exp_err;

`ifdef ARM_ENC_FASTIMM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    always #5 clk = ~clk;

    arm_ins_encoder #(.ROT_STEPS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_cond(in_cond), .in_opcode(in_opcode),
        .in_setflags(in_setflags), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_shifttype(in_shifttype), .in_shiftby(in_shiftby), .in_imm32(in_imm32),
        .in_link(in_link), .in_offset(in_offset),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ins(out_ins), .out_err(out_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Reference model: arithmetic field placement, brute-force immediate search
    // over every (rotation, byte) pair in increasing rotation order.
    task automatic model(input logic [1:0] k, input logic [3:0] c, op, input logic s,
                         input logic [3:0] rn, rd, rm, input logic [1:0] st,
                         input logic [4:0] sb, input logic [31:0] imm, input logic l,
                         input logic [23:0] off,
                         output logic [31:0] ins, output logic err, output int lat);
        bit found;
        int frot, fv;
        ins = 0; err = 0; lat = 1;
        found = 0; frot = 0; fv = 0;
        case (k)
            2'd0: ins = 32'(c) * 32'h1000_0000 + 32'(op) * 32'h20_0000 + 32'(s) * 32'h10_0000
                      + 32'(rn) * 32'h1_0000 + 32'(rd) * 32'h1000 + 32'(sb) * 32'h80
                      + 32'(st) * 32'h20 + 32'(rm);
            2'd1: begin
                for (int rot = 0; rot < 16 && !found; rot++)
                    for (int v = 0; v < 256 && !found; v++)
                        if (ror(32'(v), 2 * rot) == imm) begin
                            found = 1; frot = rot; fv = v;
                        end
                if (found) begin
                    ins = 32'(c) * 32'h1000_0000 + 32'h0200_0000 + 32'(op) * 32'h20_0000
                        + 32'(s) * 32'h10_0000 + 32'(rn) * 32'h1_0000 + 32'(rd) * 32'h1000
                        + 32'(frot) * 32'h100 + 32'(fv);
                    lat = FAST ? 2 : frot + 2;
                end else begin
                    err = 1;
                    lat = FAST ? 2 : 17;
                end
            end
            2'd2: ins = 32'(c) * 32'h1000_0000 + 32'h0A00_0000 + 32'(l) * 32'h100_0000 + 32'(off);
            default: err = 1;
        endcase
    endtask

    // Every cycle a result is presented it must match the model and the
    // encoder must be refusing new work.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("out_ins", out_ins, exp_ins);
            chk("out_err", 32'(out_err), 32'(exp_err));
            chk("in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    task automatic drive(input logic [1:0] k, input logic [3:0] c, op, input logic s,
                         input logic [3:0] rn, rd, rm, input logic [1:0] st,
                         input logic [4:0] sb, input logic [31:0] imm, input logic l,
                         input logic [23:0] off);
        in_kind = k; in_cond = c; in_opcode = op; in_setflags = s;
        in_rn = rn; in_rd = rd; in_rm = rm; in_shifttype = st; in_shiftby = sb;
        in_imm32 = imm; in_link = l; in_offset = off;
    endtask

    // One full transaction. lit_lat < 0 means no hand-computed literal.
    task automatic send(input string nm, input logic [1:0] k, input logic [3:0] c, op,
                        input logic s, input logic [3:0] rn, rd, rm, input logic [1:0] st,
                        input logic [4:0] sb, input logic [31:0] imm, input logic l,
                        input logic [23:0] off, input logic [31:0] lit_ins,
                        input logic lit_err, input int lit_lat, input int stall);
        logic [31:0] mi;
        logic        me;
        int          ml, lat;
        model(k, c, op, s, rn, rd, rm, st, sb, imm, l, off, mi, me, ml);
        exp_ins = mi; exp_err = me;
        @(negedge clk);
        chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
        drive(k, c, op, s, rn, rd, rm, st, sb, imm, l, off);
        in_valid  = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Fields must be ignored after the accept cycle.
        drive(2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom), 2'($urandom), 5'($urandom), $urandom,
              1'($urandom), 24'($urandom));
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
        chk({nm, "_latency"}, 32'(lat), 32'(ml));
        if (lit_lat >= 0) begin
            chk({nm, "_lit_ins"}, out_ins, lit_ins);
            chk({nm, "_lit_err"}, 32'(out_err), 32'(lit_err));
            chk({nm, "_lit_lat"}, 32'(lat), 32'(lit_lat));
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (out_valid && lat < 4);
        chk({nm, "_drop_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        exp_ins = '0; exp_err = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ins", out_ins, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        //   name      k  cond  op    S  rn rd rm st sb  imm32          L  offset       lit_ins        err lat                 stall
        send("addreg", 0, 4'hE, 4'h4, 1, 1, 2, 3, 0, 0,  32'h0,         0, 24'h0,      32'hE091_2003, 0, 1,                  0);
        send("movff",  1, 4'hE, 4'hD, 0, 0, 0, 0, 0, 0,  32'h0000_00FF, 0, 24'h0,      32'hE3A0_00FF, 0, 2,                  0);
        send("movrot", 1, 4'hE, 4'hD, 0, 0, 1, 0, 0, 0,  32'h0003_FC00, 0, 24'h0,      32'hE3A0_1BFF, 0, FAST ? 2 : 13,      0);
        send("unenc",  1, 4'hE, 4'hD, 0, 0, 1, 0, 0, 0,  32'h0000_0101, 0, 24'h0,      32'h0,         1, FAST ? 2 : 17,      0);
        send("bl",     2, 4'hE, 4'h0, 0, 0, 0, 0, 0, 0,  32'h0,         1, 24'h000010, 32'hEB00_0010, 0, 1,                  0);
        send("bne",    2, 4'h1, 4'h0, 0, 0, 0, 0, 0, 0,  32'h0,         0, 24'hFFFFFE, 32'h1AFF_FFFE, 0, 1,                  0);
        send("rsvd",   3, 4'hE, 4'h4, 1, 1, 2, 3, 0, 0,  32'h0,         0, 24'h0,      32'h0,         1, 1,                  0);
        send("subasr", 0, 4'h0, 4'h2, 0, 15, 14, 7, 2, 31, 32'h0,       0, 24'h0,      32'h0,         0, -1,                 0);
        send("wrap",   1, 4'hA, 4'hC, 1, 3, 4, 0, 0, 0,  32'hF000_000F, 0, 24'h0,      32'h0,         0, -1,                 0);
        send("zero",   1, 4'hF, 4'h2, 0, 5, 6, 0, 0, 0,  32'h0,         0, 24'h0,      32'h0,         0, -1,                 0);
        send("top",    1, 4'h0, 4'hF, 0, 0, 9, 0, 0, 0,  32'hFF00_0000, 0, 24'h0,      32'h0,         0, -1,                 0);
        send("nvcond", 2, 4'hF, 4'h0, 0, 0, 0, 0, 0, 0,  32'h0,         1, 24'h123456, 32'hFB12_3456, 0, 1,                  0);
        send("stall",  0, 4'h3, 4'hA, 1, 8, 9, 10, 3, 17, 32'h0,        0, 24'h0,      32'h0,         0, -1,                 5);

        // Abort mid-SEARCH with reset.
        @(negedge clk);
        drive(1, 4'hE, 4'hD, 0, 0, 1, 0, 0, 0, 32'h0000_0101, 0, 0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_ins", out_ins, 32'd0);
        chk("abort_out_err", 32'(out_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_hold_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        send("after",  1, 4'hE, 4'hD, 0, 0, 0, 0, 0, 0,  32'h0000_00FF, 0, 24'h0,      32'hE3A0_00FF, 0, 2,                  0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
